// File: rtl/exe_div_if.sv
// Handshake bundle between the EXE stage and the iterative divider.
// The EXE stage drives the request side; the divider returns the result,
// a one-cycle ready pulse and the combinational stall request.
interface exe_div_if #(
    parameter int DATA_W = 32
);
    logic                  flush;
    logic                  div_start;
    logic                  div_signed;
    logic [DATA_W-1:0]     div_op1;
    logic [DATA_W-1:0]     div_op2;
    logic [2*DATA_W-1:0]   div_result;
    logic                  div_ready;
    logic                  stallreq_div;

    modport master (
        output flush,
        output div_start,
        output div_signed,
        output div_op1,
        output div_op2,
        input  div_result,
        input  div_ready,
        input  stallreq_div
    );

    modport slave (
        input  flush,
        input  div_start,
        input  div_signed,
        input  div_op1,
        input  div_op2,
        output div_result,
        output div_ready,
        output stallreq_div
    );
endinterface

// File: rtl/exe_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EXE stage.
// Signed operands are divided as magnitudes and the quotient/remainder are
// sign-corrected on the way out. The result is {remainder, quotient} and is
// held until the next completed divide or reset. The EXE stage is stalled
// through stallreq_div until the single-cycle div_ready pulse.
module exe_div #(
    parameter int DATA_W = 32
) (
    input  logic     cpu_clk_50M,
    input  logic     cpu_rst_n,     // active-high asynchronous reset
    exe_div_if.slave bus
);
    localparam int                CNT_W    = $clog2(DATA_W);
    localparam int                WORK_W   = 2 * DATA_W + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIVZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [WORK_W-1:0]      work_q, work_d;
    logic [DATA_W-1:0]      divisor_q, divisor_d;
    logic                   neg_quot_q, neg_quot_d;
    logic                   neg_rem_q, neg_rem_d;
    logic                   div_zero_q, div_zero_d;
    logic [2*DATA_W-1:0]    div_result_q, div_result_d;
    logic                   div_ready_q, div_ready_d;

    logic                   abort_s;
    logic [DATA_W-1:0]      op1_abs_s;
    logic [DATA_W-1:0]      op2_abs_s;
    logic [WORK_W-1:0]      shifted_s;
    logic [DATA_W:0]        trial_s;
    logic [WORK_W-1:0]      step_s;
    logic [DATA_W-1:0]      quot_fix_s;
    logic [DATA_W-1:0]      rem_fix_s;

    // Operand magnitudes: DIV works on |op|, DIVU takes operands as-is.
    always_comb begin
        op1_abs_s = bus.div_op1;
        op2_abs_s = bus.div_op2;
        if (bus.div_signed && bus.div_op1[DATA_W-1]) begin
            op1_abs_s = {DATA_W{1'b0}} - bus.div_op1;
        end else begin
            op1_abs_s = bus.div_op1;
        end
        if (bus.div_signed && bus.div_op2[DATA_W-1]) begin
            op2_abs_s = {DATA_W{1'b0}} - bus.div_op2;
        end else begin
            op2_abs_s = bus.div_op2;
        end
    end

    // One restoring step: shift, trial-subtract from the upper half, keep on non-negative.
    always_comb begin
        shifted_s = work_q << 1;
        trial_s   = shifted_s[WORK_W-1:DATA_W] - {1'b0, divisor_q};
        if (trial_s[DATA_W]) begin
            step_s = shifted_s;
        end else begin
            step_s = {trial_s, shifted_s[DATA_W-1:1], 1'b1};
        end
    end

    // Sign correction: quotient negative when signs differ, remainder follows dividend.
    always_comb begin
        quot_fix_s = work_q[DATA_W-1:0];
        rem_fix_s  = work_q[2*DATA_W-1:DATA_W];
        if (neg_quot_q) begin
            quot_fix_s = {DATA_W{1'b0}} - work_q[DATA_W-1:0];
        end else begin
            quot_fix_s = work_q[DATA_W-1:0];
        end
        if (neg_rem_q) begin
            rem_fix_s = {DATA_W{1'b0}} - work_q[2*DATA_W-1:DATA_W];
        end else begin
            rem_fix_s = work_q[2*DATA_W-1:DATA_W];
        end
    end

    assign abort_s = bus.flush | ~bus.div_start;

    // Next-state and datapath control for the divide sequence.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        work_d       = work_q;
        divisor_d    = divisor_q;
        neg_quot_d   = neg_quot_q;
        neg_rem_d    = neg_rem_q;
        div_zero_d   = div_zero_q;
        div_result_d = div_result_q;
        div_ready_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The ready cycle is the one in which the pipeline advances, so a
                // start seen then still belongs to the divide that just finished.
                if (bus.div_start && !bus.flush && !div_ready_q) begin
                    work_d     = {{(DATA_W + 1){1'b0}}, op1_abs_s};
                    divisor_d  = op2_abs_s;
                    neg_quot_d = bus.div_signed & (bus.div_op1[DATA_W-1] ^ bus.div_op2[DATA_W-1]);
                    neg_rem_d  = bus.div_signed & bus.div_op1[DATA_W-1];
                    count_d    = {CNT_W{1'b0}};
                    if (bus.div_op2 == {DATA_W{1'b0}}) begin
                        div_zero_d = 1'b1;
                        state_d    = S_DIVZERO;
                    end else begin
                        div_zero_d = 1'b0;
                        state_d    = S_ON;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DIVZERO: begin
                if (abort_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_END;
                end
            end
            S_ON: begin
                if (abort_s) begin
                    state_d = S_IDLE;
                end else begin
                    work_d  = step_s;
                    count_d = count_q + {{(CNT_W - 1){1'b0}}, 1'b1};
                    if (count_q == LAST_CNT) begin
                        state_d = S_END;
                    end else begin
                        state_d = S_ON;
                    end
                end
            end
            S_END: begin
                if (abort_s) begin
                    state_d = S_IDLE;
                end else begin
                    // Divide-by-zero is architecturally unpredictable; return zero.
                    if (div_zero_q) begin
                        div_result_d = {(2 * DATA_W){1'b0}};
                    end else begin
                        div_result_d = {rem_fix_s, quot_fix_s};
                    end
                    div_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst_n) begin
        if (cpu_rst_n) begin
            state_q      <= S_IDLE;
            count_q      <= {CNT_W{1'b0}};
            work_q       <= {WORK_W{1'b0}};
            divisor_q    <= {DATA_W{1'b0}};
            neg_quot_q   <= 1'b0;
            neg_rem_q    <= 1'b0;
            div_zero_q   <= 1'b0;
            div_result_q <= {(2 * DATA_W){1'b0}};
            div_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            work_q       <= work_d;
            divisor_q    <= divisor_d;
            neg_quot_q   <= neg_quot_d;
            neg_rem_q    <= neg_rem_d;
            div_zero_q   <= div_zero_d;
            div_result_q <= div_result_d;
            div_ready_q  <= div_ready_d;
        end
    end

    assign bus.div_result   = div_result_q;
    assign bus.div_ready    = div_ready_q;
    assign bus.stallreq_div = bus.div_start & ~div_ready_q;

endmodule

// File: tb/tb_exe_div.sv
// Bench for exe_div: directed corner cases, randomized divides against an
// arithmetic reference, flush/abort, asynchronous reset and back-to-back use.
module tb_exe_div;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [63:0] last_exp = 64'd0;

    always #5 clk = ~clk;

    exe_div_if #(.DATA_W(32)) bus ();

    exe_div #(.DATA_W(32)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst),
        .bus         (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division; C-style truncation gives a remainder
    // that follows the dividend, and the 32-bit truncation covers the overflow case.
    function automatic logic [63:0] ref_div(input bit sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    // Issue one divide, measure latency from the sampling edge and check the result.
    task automatic run_div(input bit sg, input logic [31:0] a, input logic [31:0] b,
                           input bit keep, input bit scramble, input string tag);
        logic [63:0] exp;
        int          lat_exp;
        int          lat;
        int          stall_cnt;
        bit          got;
        exp       = ref_div(sg, a, b);
        lat_exp   = (b == 32'd0) ? 2 : 33;
        @(negedge clk);
        bus.div_start  = 1'b1;
        bus.div_signed = sg;
        bus.div_op1    = a;
        bus.div_op2    = b;
        got       = 1'b0;
        lat       = -1;
        stall_cnt = 0;
        for (int e = 0; e < 60 && !got; e++) begin
            @(posedge clk);
            #1;
            if (bus.div_ready === 1'b1) begin
                got = 1'b1;
                lat = e;
                check_eq({tag, " stall_in_ready"}, 64'(bus.stallreq_div), 64'd0);
                check_eq({tag, " result"}, bus.div_result, exp);
            end else begin
                if (bus.stallreq_div === 1'b1) stall_cnt++;
                if (scramble && e == 3) begin
                    bus.div_op1 = $urandom;
                    bus.div_op2 = $urandom;
                end
            end
        end
        check_eq({tag, " ready_seen"}, 64'(got), 64'd1);
        check_eq({tag, " latency"}, 64'(lat), 64'(lat_exp));
        check_eq({tag, " stall_cycles"}, 64'(stall_cnt), 64'(lat_exp));
        if (got) last_exp = exp;
        // Pipeline-advance edge: ready must be gone and the result held.
        @(posedge clk);
        #1;
        check_eq({tag, " ready_pulse"}, 64'(bus.div_ready), 64'd0);
        check_eq({tag, " hold"}, bus.div_result, last_exp);
        if (!keep) bus.div_start = 1'b0;
    endtask

    // Start a divide and abort it after the 10th edge via flush or dropped start.
    task automatic abort_div(input bit use_flush, input string tag);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        bus.div_start  = 1'b1;
        bus.div_signed = 1'b0;
        bus.div_op1    = $urandom;
        bus.div_op2    = $urandom_range(1, 1000);
        for (int e = 0; e < 10; e++) begin
            @(posedge clk);
            #1;
            if (bus.div_ready === 1'b1) seen = 1'b1;
        end
        if (use_flush) bus.flush = 1'b1;
        else           bus.div_start = 1'b0;
        @(posedge clk);
        #1;
        bus.flush     = 1'b0;
        bus.div_start = 1'b0;
        for (int e = 0; e < 45; e++) begin
            @(posedge clk);
            #1;
            if (bus.div_ready === 1'b1) seen = 1'b1;
        end
        check_eq({tag, " no_ready"}, 64'(seen), 64'd0);
        check_eq({tag, " result_kept"}, bus.div_result, last_exp);
        check_eq({tag, " stall_low"}, 64'(bus.stallreq_div), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, b;
        bit          sg;
        int          sel;

        bus.flush      = 1'b0;
        bus.div_start  = 1'b0;
        bus.div_signed = 1'b0;
        bus.div_op1    = 32'd0;
        bus.div_op2    = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("reset result", bus.div_result, 64'd0);
        check_eq("reset ready", 64'(bus.div_ready), 64'd0);
        check_eq("reset stall", 64'(bus.stallreq_div), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div(1'b0, 32'd100, 32'd7, 1'b0, 1'b0, "divu_100_7");
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "div_m7_2");
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_ovf");
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, "divu_max_1");
        run_div(1'b0, 32'd5, 32'd0, 1'b0, 1'b0, "divu_by_zero");
        run_div(1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b0, "div_by_zero");
        run_div(1'b1, 32'h1234_5678, 32'hFFFF_FF00, 1'b0, 1'b1, "div_scramble");

        abort_div(1'b1, "abort_flush");
        run_div(1'b0, 32'd1000, 32'd33, 1'b0, 1'b0, "after_flush");
        abort_div(1'b0, "abort_nostart");
        run_div(1'b1, 32'hFFFF_0000, 32'd77, 1'b0, 1'b0, "after_nostart");

        for (int i = 0; i < 24; i++) begin
            sg  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 5);
            a   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case (sel)
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'd0 - 32'($urandom_range(1, 9));
                default: b = 32'($urandom);
            endcase
            run_div(sg, a, b, 1'b0, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        bus.div_start  = 1'b1;
        bus.div_signed = 1'b0;
        bus.div_op1    = 32'd1000;
        bus.div_op2    = 32'd3;
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst result", bus.div_result, 64'd0);
        check_eq("async_rst ready", 64'(bus.div_ready), 64'd0);
        last_exp = 64'd0;
        bus.div_start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("post_rst ready", 64'(bus.div_ready), 64'd0);

        run_div(1'b0, 32'd123456, 32'd789, 1'b1, 1'b0, "b2b_0");
        run_div(1'b1, 32'hFFFF_FC00, 32'd10, 1'b1, 1'b0, "b2b_1");
        run_div(1'b0, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0, "b2b_2");
        run_div(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, "b2b_3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
